// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, 4 registers and a level interrupt.
// Latency: TXDATA write at edge N drives the start bit from edge N+1; frame = 10 (11 with parity) x BAUDDIV cycles.
// Backpressure: none on the bus; a push into a full FIFO is dropped and sets sticky overflow.
// Optional even-parity bit: define UART_TX_PARITY_EN (adds CTRL bit1 parity_en and a PARITY state).
module io_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd868,
    parameter logic [4:0]  IRQ_ID      = 5'd3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_write_data,
    input  logic        io_write_en,
    output logic [31:0] io_read_data,
    output logic        interrupt,
    output logic [4:0]  interrupt_id,
    output logic        tx
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [AW-1:0] P_ONE   = AW'(1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t          r_state;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_overflow;
    logic            r_irq_en;
    logic [15:0]     r_div;
    logic [15:0]     r_baud_cnt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_tx;
    logic            r_irq;
`ifdef UART_TX_PARITY_EN
    logic            r_parity_en;
    logic            r_parity;
`endif

    logic            w_hit;
    logic            w_wr;
    logic [1:0]      w_off;
    logic            w_push_req;
    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic            w_full;
    logic            w_bit_end;
    logic [7:0]      w_head;
    logic            w_unused;

    assign w_hit      = (io_addr[31:4] == BASE_ADDR[31:4]);
    assign w_wr       = w_hit & io_write_en;
    assign w_off      = io_addr[3:2];
    assign w_push_req = w_wr & (w_off == 2'd0);
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == C_DEPTH);
    // ">=" so a BAUDDIV shrunk below the running count ends the bit right away
    assign w_bit_end  = (r_baud_cnt >= (r_div - 16'd1));
    // FSM takes a byte when leaving IDLE or when chaining frames at the end of STOP
    assign w_pop      = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
    // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_unused   = ^{io_write_data[31:16], io_addr[1:0]};

    assign tx           = r_tx;
    assign interrupt    = r_irq;
    assign interrupt_id = IRQ_ID;

    // FIFO storage, written on accepted pushes only
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= io_write_data[7:0];
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + P_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + P_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_ONE;
                2'b01:   r_count <= r_count - C_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Software-visible control state: overflow flag, CTRL, BAUDDIV
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_overflow  <= 1'b0;
            r_irq_en    <= 1'b0;
            r_div       <= DEFAULT_DIV;
`ifdef UART_TX_PARITY_EN
            r_parity_en <= 1'b0;
`endif
        end else begin
            if (w_push_req && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end else if (w_wr && (w_off == 2'd1) && io_write_data[3]) begin
                r_overflow <= 1'b0;
            end
            if (w_wr && (w_off == 2'd2)) begin
                r_irq_en    <= io_write_data[0];
`ifdef UART_TX_PARITY_EN
                r_parity_en <= io_write_data[1];
`endif
            end
            if (w_wr && (w_off == 2'd3)) begin
                r_div <= (io_write_data[15:0] == 16'd0) ? 16'd1 : io_write_data[15:0];
            end
        end
    end

    // Serialiser FSM; tx and interrupt are registered here so the line never glitches
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_irq      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_irq <= r_irq_en & w_empty & (r_state == S_IDLE);
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (!w_empty) begin
                        r_shift    <= w_head;
                        r_baud_cnt <= '0;
                        r_tx       <= 1'b0;
                        r_state    <= S_START;
`ifdef UART_TX_PARITY_EN
                        r_parity   <= ^w_head;
`endif
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_tx       <= r_shift[0];
                        r_state    <= S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            if (r_parity_en) begin
                                r_tx    <= r_parity;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
`else
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_tx       <= 1'b1;
                        r_state    <= S_STOP;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (!w_empty) begin
                            r_shift  <= w_head;
                            r_tx     <= 1'b0;
                            r_state  <= S_START;
`ifdef UART_TX_PARITY_EN
                            r_parity <= ^w_head;
`endif
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Register read mux; undecoded addresses and unused bits read as 0
    always_comb begin
        io_read_data = '0;
        if (w_hit) begin
            case (w_off)
                2'd1: begin
                    io_read_data[0]    = (r_state != S_IDLE);
                    io_read_data[1]    = w_full;
                    io_read_data[2]    = w_empty;
                    io_read_data[3]    = r_overflow;
                    io_read_data[16:8] = 9'(r_count);
                end
                2'd2: begin
                    io_read_data[0] = r_irq_en;
`ifdef UART_TX_PARITY_EN
                    io_read_data[1] = r_parity_en;
`endif
                end
                2'd3:    io_read_data[15:0] = r_div;
                default: io_read_data = '0;
            endcase
        end
    end

endmodule

// File: doc/io_uart_tx.md
Name: io_uart_tx

Overview:
- Memory-mapped UART transmitter that sits on the IO side of system_bus.
- Acts as a bus responder to CPU-initiated io_addr/io_write_data/io_write_en transactions and returns register contents on io_read_data.
- Buffers bytes in a FIFO, serialises them 8N1 (LSB first) on tx, and raises a level interrupt toward the CPU when the transmitter drains.

Parameters:
- BASE_ADDR, 32'h0000_1000, byte address of register block; decode matches io_addr[31:4] == BASE_ADDR[31:4].
- FIFO_DEPTH, 16, TX FIFO entries; power of two, 2..256.
- DEFAULT_DIV, 16'd868, reset value of BAUDDIV (clock cycles per bit).
- IRQ_ID, 5'd3, value driven on interrupt_id.

Ports:
- clock, input, 1, system clock; all state on rising edge.
- reset, input, 1, asynchronous, active-low; 0 = reset.
- io_addr, input, 32, bus byte address from system_bus.
- io_write_data, input, 32, write data.
- io_write_en, input, 1, write strobe; one write per cycle when high and address decodes.
- io_read_data, output, 32, register read data; combinational from io_addr and current state.
- interrupt, output, 1, level interrupt request.
- interrupt_id, output, 5, constant IRQ_ID.
- tx, output, 1, serial line; idle high.

Behaviour:
- Register map (offset io_addr[3:2]):
  - 0x0 TXDATA: write pushes io_write_data[7:0]; reads 0.
  - 0x4 STATUS, read-only except bit3:
    - bit0 busy (FSM not IDLE)
    - bit1 full
    - bit2 empty
    - bit3 overflow (sticky; write 1 to clear)
    - bits[16:8] FIFO count
  - 0x8 CTRL: bit0 irq_en. Read/write; reset 0.
  - 0xC BAUDDIV: bits[15:0]. Read/write; reset DEFAULT_DIV. A write of 0 is stored as 1.
- Undecoded address: io_read_data = 0; writes ignored. Unused read bits are 0.
- Reset values: tx=1, interrupt=0, FIFO empty, overflow=0, FSM IDLE, baud counter 0. Reset is asynchronous; tx returns to 1 immediately, including mid-frame.
- FIFO:
  - Push when a TXDATA write hits and the FIFO is not full.
  - A push while full is dropped and sets overflow.
  - Pop when the FSM leaves IDLE.
  - Simultaneous push and pop are both performed in the same cycle, even when full (the pop frees the slot); count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO is non-empty, on the next edge load the shift register from the FIFO head, pop, go to START, baud counter = 0.
  - Each state holds for BAUDDIV cycles: counter increments; on counter == BAUDDIV-1 it clears and the state advances.
  - START: tx=0.
  - DATA: tx=shift[0], shifting right per bit; 8 bits, bit index 0..7. Advance to STOP after bit 7.
  - STOP: tx=1. At the end of the bit, go to START directly (back-to-back, no idle gap) if the FIFO is non-empty, otherwise IDLE.
- Latency: TXDATA write at edge N with FIFO empty and FSM IDLE → push at N, FSM in START after edge N+1, tx falls at N+1. Frame length = 10×BAUDDIV cycles.
- A BAUDDIV write mid-frame takes effect immediately; the counter compares against the new value. If counter ≥ new value, the bit ends on the next cycle.
- tx is driven from a register (glitch-free).
- interrupt: registered. Equals irq_en & empty & FSM==IDLE, updated each cycle; remains asserted until a byte is pushed or irq_en is cleared.

Optional Feature:
- UART_TX_PARITY_EN, defined:
  - Adds CTRL bit1 parity_en (reset 0) and a PARITY state between DATA and STOP driving even parity (XOR of the 8 data bits).
  - With parity_en=1, frame length is 11×BAUDDIV.
- Undefined: CTRL bit1 reads 0, writes ignored, no PARITY state, 8N1 only.

Test Plan:
- Reset: hold reset=0 mid-operation → tx=1, interrupt=0, STATUS reads 0x0000_0004; after release, BAUDDIV reads 868.
- Single byte: BAUDDIV=4, write 0xA5 to TXDATA → tx sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, starting 1 cycle after the write; busy=1 throughout.
- Back-to-back: BAUDDIV=2, push 0x01, 0x80, 0xFF → three 20-cycle frames with no idle gap; STATUS count decrements 2,1,0 as each frame starts.
- Overflow: stall FSM with BAUDDIV=0xFFFF, write 18 bytes → count=16, full=1, overflow=1. Write 0x8 to STATUS → overflow=0. First frame transmits the first byte written.
- Interrupt: CTRL=1, push 0x55 with BAUDDIV=3 → interrupt=0 while busy, rises 1 cycle after the STOP bit ends, interrupt_id=3. Write CTRL=0 → interrupt falls the next cycle.
- Parity (UART_TX_PARITY_EN, CTRL=0x3): send 0x07 → parity bit 1, 11-bit frame. Send 0x03 → parity bit 0.
